// File: rtl/cdc_arb_pkg.sv
// Shared types and width helper for the async-FIFO write arbiter.
package cdc_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Bits needed to index n items; never less than one so 1-entry cases still get a port.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first asserted request at or after i_start, wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic          o_found,
  output logic [IW-1:0] o_index
);

  logic [IW:0] w_sum;

  // Walk from the far end back towards i_start so the nearest hit is written last.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_sum   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_start} + (IW + 1)'(k);
      if (w_sum >= (IW + 1)'(N)) begin
        w_sum = w_sum - (IW + 1)'(N);
      end
      if (i_req[w_sum[IW-1:0]]) begin
        o_found = 1'b1;
        o_index = w_sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/cdc_wr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ beat streams into one async-FIFO write port.
// A grant lasts one packet (capped at MAX_BURST beats) and is revoked after IDLE_TIMEOUT quiet cycles.
module cdc_wr_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64,
  localparam int ID_W        = id_w(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           fifo_wr_en,
  output logic [ID_W+1+DATA_WIDTH-1:0]   fifo_wr_data,
  input  logic                           fifo_wr_full,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int BC_W = id_w(MAX_BURST);
  localparam int IC_W = id_w(IDLE_TIMEOUT);

  arb_state_t       r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_grant_id;
  logic [BC_W-1:0]  r_beat_cnt;
  logic [IC_W-1:0]  r_idle_cnt;
  logic             r_timeout;

  logic                  w_found;
  logic [ID_W-1:0]       w_pick;
  logic                  w_in_grant;
  logic                  w_gnt_vld;
  logic                  w_gnt_last;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                  w_xfer;
  logic                  w_eff_last;
  logic                  w_timeout_hit;
  logic [ID_W-1:0]       w_next_ptr;

  rr_picker #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_picker (
    .i_req   (req_valid),
    .i_start (r_rr_ptr),
    .o_found (w_found),
    .o_index (w_pick)
  );

  // Everything visible is gated by rst so a mid-burst reset drops the grant immediately.
  assign w_in_grant    = (r_state == ARB_GRANT) & ~rst;
  assign w_gnt_vld     = req_valid[r_grant_id];
  assign w_gnt_last    = req_last[r_grant_id];
  assign w_gnt_data    = req_data[int'(r_grant_id) * DATA_WIDTH +: DATA_WIDTH];
  assign w_xfer        = w_in_grant & w_gnt_vld & ~fifo_wr_full;
  assign w_eff_last    = w_gnt_last | (r_beat_cnt == BC_W'(MAX_BURST - 1));
  assign w_timeout_hit = w_in_grant & ~w_gnt_vld & ~fifo_wr_full &
                         (r_idle_cnt == IC_W'(IDLE_TIMEOUT - 1));
  assign w_next_ptr    = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  assign req_ready    = w_xfer ? (NUM_REQ'(1) << r_grant_id) : '0;
  assign fifo_wr_en   = w_xfer;
  assign fifo_wr_data = {r_grant_id, w_eff_last, w_gnt_data};
  assign busy         = w_in_grant;
  assign timeout_err  = r_timeout & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_grant_id <= w_pick;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
            r_state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (w_xfer) begin
            r_idle_cnt <= '0;
            if (w_eff_last) begin
              r_state  <= ARB_IDLE;
              r_rr_ptr <= w_next_ptr;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end else if (w_gnt_vld) begin
            r_idle_cnt <= '0;
          end else if (!fifo_wr_full) begin
            // A full FIFO freezes the quiet-cycle count as well as the beat count.
            if (w_timeout_hit) begin
              r_timeout <= 1'b1;
              r_state   <= ARB_IDLE;
              r_rr_ptr  <= w_next_ptr;
            end else begin
              r_idle_cnt <= r_idle_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_wr_arbiter.sv
// Scoreboard bench for cdc_wr_arbiter: directed packets per requester, FIFO words checked in order.
module tb_cdc_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IT = 64;
  localparam int IW = 2;
  localparam int FW = IW + 1 + DW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            fifo_wr_en;
  logic [FW-1:0]   fifo_wr_data;
  logic            fifo_wr_full = 1'b0;
  logic            busy;
  logic            timeout_err;

  cdc_wr_arbiter #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .MAX_BURST    (16),
    .IDLE_TIMEOUT (IT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_full (fifo_wr_full),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Per-requester beat lists {last, data}; the driver presents the head and pops on ready.
  logic [DW:0] bmem [NR][64];
  int          bcnt [NR];
  int          bptr [NR];

  logic [FW-1:0] exp_q[$];

  function automatic logic [DW-1:0] dv(input int id, input int b);
    return 32'hA000_0000 | DW'(id << 8) | DW'(b);
  endfunction

  task automatic load(input int id, input int b, input logic last);
    bmem[id][bcnt[id]] = {last, dv(id, b)};
    bcnt[id]++;
  endtask

  task automatic expect_w(input int id, input int b, input logic last);
    exp_q.push_back({IW'(id), last, dv(id, b)});
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      bcnt[i] = 0;
      bptr[i] = 0;
    end
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (bptr[i] < bcnt[i]) begin
          req_valid[i]          = 1'b1;
          req_last[i]           = bmem[i][bptr[i]][DW];
          req_data[i*DW +: DW]  = bmem[i][bptr[i]][DW-1:0];
        end else begin
          req_valid[i]          = 1'b0;
          req_last[i]           = 1'b0;
          req_data[i*DW +: DW]  = '0;
        end
      end
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i] && bptr[i] < bcnt[i]) bptr[i]++;
      end
    end
  end

  // Monitor: owns its cycle count, pops the scoreboard on every FIFO write.
  int            ncyc    = 0;
  int            last_wr = -1;
  int            to_cyc  = -1;
  int            to_seen = 0;
  logic          prev_to = 1'b0;
  logic          chk_gap = 1'b0;
  logic [FW-1:0] exp_w;

  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write", 64'(fifo_wr_data), 64'hDEAD);
        end else begin
          exp_w = exp_q.pop_front();
          check_eq("fifo_word", 64'(fifo_wr_data), 64'(exp_w));
        end
        check_eq("ready_onehot", 64'(req_ready), 64'(NR'(1) << fifo_wr_data[FW-1 -: IW]));
        if (chk_gap && last_wr >= 0) check_eq("grant_gap", 64'(ncyc - last_wr), 64'd2);
        last_wr = ncyc;
      end else if (req_ready != '0) begin
        check_eq("ready_without_write", 64'(req_ready), 64'd0);
      end
      if (timeout_err) begin
        to_seen++;
        to_cyc = ncyc;
        check_eq("busy_at_timeout", 64'(busy), 64'd0);
        check_eq("timeout_single_pulse", 64'(prev_to), 64'd0);
      end
      prev_to = timeout_err;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst          = 1'b1;
    fifo_wr_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      bcnt[i] = 0;
      bptr[i] = 0;
    end
    exp_q.delete();
    @(negedge clk);
    check_eq("outputs_in_reset", 64'({req_ready, fifo_wr_en, busy, timeout_err}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_eq({name, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_writes(input int count, input int budget);
    int seen;
    int n;
    seen = 0;
    n    = 0;
    while (seen < count && n < budget) begin
      @(negedge clk);
      if (fifo_wr_en) seen++;
      n++;
    end
    check_eq("writes_reached", 64'(seen), 64'(count));
  endtask

  initial begin
    int n;
    int k;
    int bad;
    int to_base;

    // Two requesters pending, pointer at 0: 1 first, then 2.
    do_reset();
    load(1, 1, 1'b0);
    load(1, 2, 1'b1);
    load(2, 1, 1'b1);
    expect_w(1, 1, 1'b0);
    expect_w(1, 2, 1'b1);
    expect_w(2, 1, 1'b1);
    n = 0;
    while (req_valid == '0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    k = 0;
    while (!fifo_wr_en && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_eq("arb_latency", 64'(k), 64'd1);
    wait_drain("two_req", 40);

    // 20 beats without last: burst cap forces last on beat 16, rest in a new grant.
    do_reset();
    for (int b = 1; b <= 20; b++) begin
      load(0, b, 1'b0);
      expect_w(0, b, b == 16);
    end
    wait_drain("burst_cap", 80);

    // FIFO full for 10 cycles after the third beat.
    do_reset();
    for (int b = 1; b <= 8; b++) begin
      load(1, b, b == 8);
      expect_w(1, b, b == 8);
    end
    to_base = to_seen;
    wait_writes(3, 30);
    @(posedge clk);
    #1;
    fifo_wr_full = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fifo_wr_en || req_ready != '0 || timeout_err || !busy) bad++;
    end
    check_eq("full_stall", 64'(bad), 64'd0);
    @(posedge clk);
    #1;
    fifo_wr_full = 1'b0;
    wait_drain("full_resume", 40);
    check_eq("no_timeout_on_full", 64'(to_seen - to_base), 64'd0);

    // Requester 3 goes quiet after one beat; grant is revoked and pointer wraps to 0.
    do_reset();
    load(3, 1, 1'b0);
    expect_w(3, 1, 1'b0);
    to_base = to_seen;
    wait_drain("quiet_beat", 20);
    n = 0;
    while (to_seen == to_base && n < 150) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    check_eq("timeout_count", 64'(to_seen - to_base), 64'd1);
    check_eq("timeout_delay", 64'(to_cyc - last_wr), 64'(IT + 1));
    check_eq("busy_after_timeout", 64'(busy), 64'd0);
    load(3, 2, 1'b1);
    load(0, 1, 1'b1);
    expect_w(0, 1, 1'b1);
    expect_w(3, 2, 1'b1);
    wait_drain("ptr_after_timeout", 20);

    // All requesters busy with single-beat packets: strict rotation, one bubble each.
    do_reset();
    last_wr = -1;
    chk_gap = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NR; i++) begin
        load(i, r, 1'b1);
      end
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NR; i++) begin
        expect_w(i, r, 1'b1);
      end
    end
    wait_drain("rotation", 40);
    chk_gap = 1'b0;

    // Reset lands on the third beat of requester 2's burst.
    do_reset();
    load(1, 1, 1'b1);
    expect_w(1, 1, 1'b1);
    for (int b = 1; b <= 5; b++) load(2, b, b == 5);
    expect_w(2, 1, 1'b0);
    expect_w(2, 2, 1'b0);
    wait_writes(3, 30);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_burst_rst_outputs", 64'({req_ready, fifo_wr_en, busy, timeout_err}), 64'd0);
    check_eq("mid_burst_rst_queue", 64'(exp_q.size()), 64'd0);
    load(0, 7, 1'b1);
    expect_w(0, 7, 1'b1);
    expect_w(2, 3, 1'b0);
    expect_w(2, 4, 1'b0);
    expect_w(2, 5, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_idle", 64'({req_ready, fifo_wr_en, busy, timeout_err}), 64'd0);
    wait_drain("restart_from_0", 30);

    check_eq("timeout_total", 64'(to_seen), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cdc_wr_arbiter.md
CDC_WR_ARBITER -- requirements
Module: cdc_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload bits per beat.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum beats per grant, power of 2.
REQ-004 SHALL have parameter IDLE_TIMEOUT, default 64: cycles a granted requester may hold req_valid low before its grant is revoked.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, NUM_REQ: per-requester beat valid.
REQ-008 SHALL have port req_last, input, NUM_REQ: per-requester end-of-packet marker.
REQ-009 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH: packed payloads; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port req_ready, output, NUM_REQ: per-requester beat accepted.
REQ-011 SHALL have port fifo_wr_en, output, 1: write strobe to the async FIFO write port.
REQ-012 SHALL have port fifo_wr_data, output, ID_W+1+DATA_WIDTH, where ID_W = clog2(NUM_REQ): the word {src_id, last, payload}.
REQ-013 SHALL have port fifo_wr_full, input, 1: FIFO full flag, same clock domain.
REQ-014 SHALL have port busy, output, 1: a grant is held.
REQ-015 SHALL have port timeout_err, output, 1: one-cycle pulse when a grant is revoked by timeout.

Function
REQ-016 SHALL implement states IDLE and GRANT.
REQ-017 In IDLE with any req_valid high, SHALL select the first asserted requester found from rr_ptr upward (modulo NUM_REQ), register it as grant_id, and enter GRANT on the next cycle; this gives 1 cycle of arbitration latency.
REQ-018 In IDLE, SHALL hold req_ready and fifo_wr_en at 0.
REQ-019 In GRANT, a beat SHALL transfer when req_valid[grant_id] is high and fifo_wr_full is low.
REQ-020 req_ready[grant_id] and fifo_wr_en SHALL be combinational and equal to the transfer condition; all other req_ready bits SHALL be 0.
REQ-021 fifo_wr_data SHALL be {grant_id, eff_last, req_data slice of grant_id}; eff_last = req_last[grant_id] OR (beat_cnt == MAX_BURST-1).
REQ-022 beat_cnt SHALL reset to 0 on each grant and increment per transferred beat.
REQ-023 A transfer with eff_last = 1 SHALL return to IDLE and set rr_ptr = grant_id+1, wrapping NUM_REQ-1 to 0.
REQ-024 In GRANT, idle_cnt SHALL increment each cycle req_valid[grant_id] is low, and clear to 0 on any cycle it is high.
REQ-025 On idle_cnt reaching IDLE_TIMEOUT-1 with req_valid still low, SHALL pulse timeout_err, return to IDLE, and advance rr_ptr as in REQ-023; no beat is written that cycle.
REQ-026 fifo_wr_full SHALL stall without limit and SHALL NOT advance idle_cnt or beat_cnt.
REQ-027 Changes to non-granted requesters' inputs during GRANT SHALL have no effect.
REQ-028 busy SHALL be 1 exactly in GRANT.

Reset
REQ-029 While rst is high at a clock edge, SHALL set state IDLE, rr_ptr 0, grant_id 0, beat_cnt 0, idle_cnt 0.
REQ-030 During reset, req_ready, fifo_wr_en, busy and timeout_err SHALL be 0, regardless of inputs.
REQ-031 Reset asserted mid-burst SHALL drop the grant without a last beat; the FIFO consumer tolerates truncated packets.

Structure
REQ-032 Package cdc_arb_pkg SHALL hold the state enum (ARB_IDLE, ARB_GRANT) and the ID_W helper function.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_picker, with inputs req vector and start pointer, and outputs found and index.
REQ-034 Counters SHALL be sized clog2(MAX_BURST) and clog2(IDLE_TIMEOUT) bits.

Verification
REQ-035 Reset, then req_valid=4'b0110 with rr_ptr=0: grant requester 1, first fifo_wr_en 1 cycle after valid, src_id=1; after its last, requester 2 is granted next.
REQ-036 Requester 0 streams 20 beats with req_last never set: beat 16 carries last=1, grant returns to IDLE, and beats 17..20 arrive in a new grant.
REQ-037 fifo_wr_full held high for 10 cycles mid-burst: no req_ready and no fifo_wr_en for 10 cycles, no timeout_err, and the burst then resumes with no beat lost or duplicated.
REQ-038 Granted requester 3 drops req_valid for 64 cycles: timeout_err pulses once, busy falls, and rr_ptr becomes 0.
REQ-039 All 4 requesters continuously valid with 1-beat packets: grants rotate 0,1,2,3,0 with one IDLE bubble between grants.
REQ-040 rst asserted on the 3rd beat of a 5-beat burst: the next cycle shows busy=0 and all outputs 0, and after release arbitration restarts from requester 0.
